alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational integer ALU between two requesters (e.g. execute stage and address/branch-compare unit).
- Round-robin arbitration, valid/ready handshakes on request and response sides.
- Drives the ALU's control/operand inputs from registers and captures its result/zero outputs.
- Sits between requesters and the ALU instance in the execute stage.

Parameters:
WIDTH, 32, operand/result width in bits
CTL_W, 4, ALU control code width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_op  in  CTL_W  ALU control code (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT unsigned, 12 NOR)
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_result  out  WIDTH  registered ALU result
rsp0_zero  out  1  registered ALU zero flag
rsp0_err  out  1  illegal op flag (see Optional Feature)
rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_err  same for requester 1
alu_ctl  out  CTL_W  to ALU control input
alu_a  out  WIDTH  to ALU operand A
alu_b  out  WIDTH  to ALU operand B
alu_out  in  WIDTH  from ALU result
alu_zero  in  1  from ALU zero output
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk); reset synchronous active-low (rst_n), sampled on rising edge only.
- FSM states: IDLE, EXEC, RESP.
- Reset (any cycle, including mid-operation):
  - state=IDLE; in-flight op discarded, no response issued.
  - all rsp*_valid=0, rsp*_result=0, rsp*_zero=0, rsp*_err=0.
  - alu_ctl/alu_a/alu_b=0; last_grant=1 (requester 0 wins first tie).
- IDLE:
  - reqN_ready=1 only for the winner, and only in IDLE.
  - Winner: the sole valid requester; if both valid, the one not equal to last_grant.
  - Neither valid: both ready=0, no state change.
  - On valid&ready at an edge: latch op/a/b into alu_ctl/alu_a/alu_b registers, latch owner id, go EXEC.
- EXEC (exactly one cycle):
  - ALU inputs stable from registers.
  - At end-of-cycle edge: capture alu_out/alu_zero into owner's rsp result/zero, set owner's rspN_valid=1, go RESP.
- RESP:
  - Owner's rspN_valid held with stable result/zero/err until rspN_ready=1 at an edge.
  - That edge: rspN_valid=0, last_grant=owner, go IDLE.
  - Non-owner rsp_valid stays 0.
  - reqN_ready=0 for both while busy.
- Latency and throughput:
  - Accept edge T → rsp_valid high from T+2 edge onward (T+1 is EXEC capture, visible after T+1).
  - Best-case throughput: 1 op per 3 cycles.
- alu_ctl/alu_a/alu_b keep the last operation's values outside EXEC.
- Requester inputs not sampled outside the accept edge; changes while not ready are ignored.
- busy=1 in EXEC and RESP.
- SLT (op 7) and wraparound of ADD/SUB are the ALU's responsibility; the arbiter passes values unchanged, no width extension.

Optional Feature:
- Macro ALU_ARB_OPCHECK_EN.
- Defined:
  - Op not in {0,1,2,6,7,12} at accept: go IDLE→RESP directly, skipping EXEC.
  - Response: result=0, zero=1, err=1.
  - ALU input registers not updated.
- Undefined:
  - All ops pass to the ALU unchanged; rsp*_err tied 0.

Test Plan:
- Req0 only, op=2, a=5, b=7, rsp0_ready=1 → rsp0_valid from accept+2 edges, result=12, zero=0; req1 side idle.
- Both valid every cycle, op=6, a=b=9 → grants alternate 0,1,0,1; each result=0, zero=1; req0 first after reset.
- Req1 op=7, a=3, b=4, rsp1_ready=0 for 5 cycles → rsp1_valid/result=1 held stable, req*_ready=0, busy=1; completes when ready rises.
- Req0 op=12, a=0, b=0 accepted, rst_n=0 during EXEC → next cycle IDLE, rsp0_valid=0, no response ever; req0 wins next tie.
- With ALU_ARB_OPCHECK_EN, req0 op=3 → rsp0_valid at accept+1, result=0, zero=1, err=1, alu_ctl unchanged. Without the macro, same stimulus → ALU default result 0, err=0.
- Req0 op=0, a=0xF0F0F0F0, b=0xFF00FF00 then op=1 same operands → results 0xF000F000 then 0xFFF0FFF0.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : alu_share_arbiter_if                                       |
// | Description : Request/response handshakes for two requesters plus the    |
// |               operand/result bus to the shared combinational ALU.        |
// |               slave  - arbiter view                                      |
// |               master - environment view (requesters and the ALU)         |
// | Signals     : req{0,1}_valid/ready/op/a/b  request channels              |
// |               rsp{0,1}_valid/ready/result/zero/err  response channels    |
// |               alu_ctl/alu_a/alu_b  to ALU, alu_out/alu_zero from ALU     |
// |               busy  arbiter not idle                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int CTL_W = 4
);
   logic             req0_valid, req0_ready;
   logic [CTL_W-1:0] req0_op;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready;
   logic [CTL_W-1:0] req1_op;
   logic [WIDTH-1:0] req1_a, req1_b;

   logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
   logic [WIDTH-1:0] rsp0_result;
   logic             rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
   logic [WIDTH-1:0] rsp1_result;

   logic [CTL_W-1:0] alu_ctl;
   logic [WIDTH-1:0] alu_a, alu_b, alu_out;
   logic             alu_zero;
   logic             busy;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
      output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
      input  rsp0_ready, rsp1_ready,
      output alu_ctl, alu_a, alu_b,
      input  alu_out, alu_zero,
      output busy
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
      input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
      output rsp0_ready, rsp1_ready,
      input  alu_ctl, alu_a, alu_b,
      output alu_out, alu_zero,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_share_arbiter                                          |
// | Description : Round-robin sharing of one combinational ALU between two   |
// |               requesters. IDLE accepts one request, EXEC lets the ALU    |
// |               evaluate registered operands for one cycle, RESP holds the |
// |               captured result until the owner takes it.                  |
// | Ports       : clk    rising-edge clock                                   |
// |               rst_n  synchronous active-low reset                        |
// |               bus    alu_share_arbiter_if.slave (request, response and   |
// |                      ALU channels, busy)                                 |
// | Options     : ALU_ARB_OPCHECK_EN - reject undefined op codes with an     |
// |               error response instead of passing them to the ALU          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int CTL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic             owner;        // requester whose op is in flight
   logic             last_grant;   // requester served most recently
   logic [CTL_W-1:0] ctl_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       rsp_valid, rsp_zero;
   logic [WIDTH-1:0] rsp_result [2];

   logic             any_valid, grant, accept, rsp_done, op_legal;
   logic [CTL_W-1:0] sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;

   // On a tie the requester that was not served last wins.
   always_comb begin
      any_valid = bus.req0_valid | bus.req1_valid;
      grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
      accept    = (state == IDLE) & any_valid;
      sel_op    = grant ? bus.req1_op : bus.req0_op;
      sel_a     = grant ? bus.req1_a  : bus.req0_a;
      sel_b     = grant ? bus.req1_b  : bus.req0_b;
      rsp_done  = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);
   end

`ifdef ALU_ARB_OPCHECK_EN
   logic [1:0] rsp_err;

   always_comb begin
      op_legal = 1'b0;
      case (sel_op)
         CTL_W'(0), CTL_W'(1), CTL_W'(2),
         CTL_W'(6), CTL_W'(7), CTL_W'(12): op_legal = 1'b1;
         default:                          op_legal = 1'b0;
      endcase
   end
`else
   assign op_legal = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = op_legal ? EXEC : RESP;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last_grant    <= 1'b1;
         ctl_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         rsp_valid     <= '0;
         rsp_zero      <= '0;
         rsp_result[0] <= '0;
         rsp_result[1] <= '0;
`ifdef ALU_ARB_OPCHECK_EN
         rsp_err       <= '0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  owner <= grant;
                  if (op_legal) begin
                     ctl_q <= sel_op;
                     a_q   <= sel_a;
                     b_q   <= sel_b;
                  end else begin
                     // Rejected op: answer straight away, ALU inputs untouched.
                     rsp_valid[grant]  <= 1'b1;
                     rsp_result[grant] <= '0;
                     rsp_zero[grant]   <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
                     rsp_err[grant]    <= 1'b1;
`endif
                  end
               end
            end
            EXEC: begin
               rsp_valid[owner]  <= 1'b1;
               rsp_result[owner] <= bus.alu_out;
               rsp_zero[owner]   <= bus.alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
               rsp_err[owner]    <= 1'b0;
`endif
            end
            RESP: begin
               if (rsp_done) begin
                  rsp_valid[owner] <= 1'b0;
                  last_grant       <= owner;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready  = accept & ~grant;
   assign bus.req1_ready  = accept &  grant;
   assign bus.busy        = (state != IDLE);
   assign bus.alu_ctl     = ctl_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.rsp0_valid  = rsp_valid[0];
   assign bus.rsp0_result = rsp_result[0];
   assign bus.rsp0_zero   = rsp_zero[0];
   assign bus.rsp1_valid  = rsp_valid[1];
   assign bus.rsp1_result = rsp_result[1];
   assign bus.rsp1_zero   = rsp_zero[1];
`ifdef ALU_ARB_OPCHECK_EN
   assign bus.rsp0_err    = rsp_err[0];
   assign bus.rsp1_err    = rsp_err[1];
`else
   assign bus.rsp0_err    = 1'b0;
   assign bus.rsp1_err    = 1'b0;
`endif
endmodule
`default_nettype wire
